// File: rtl/trig_pkg.sv
// Shared definitions for the trig issue scheduler: op encodings, unit latency
// and the shadow-line entry that follows each operand through the Sin/Cos units.
package trig_pkg;

    typedef enum logic [1:0] {
        OP_SIN    = 2'b00,
        OP_COS    = 2'b01,
        OP_SINCOS = 2'b10,
        OP_RSVD   = 2'b11
    } trig_op_e;

    localparam int TRIG_LATENCY = 46;
    // Widest id for up to 8 requesters; narrower configs zero-extend.
    localparam int MAX_ID_W     = 3;

    typedef struct packed {
        logic                v;
        logic [MAX_ID_W-1:0] id;
        trig_op_e            op;
    } shadow_t;

    // Reserved op runs as sincos and is reported that way.
    function automatic trig_op_e norm_op(input logic [1:0] op);
        return (op == 2'b11) ? OP_SINCOS : trig_op_e'(op);
    endfunction

endpackage

// File: rtl/trig_issue_scheduler_if.sv
// Requester, unit and response signals of the trig issue scheduler.
// slave = scheduler side, master = clients plus the external Sin/Cos pair.
interface trig_issue_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 46
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(LATENCY + 3);

    logic                       io_enable;
    logic [NUM_REQ-1:0]         io_req_valid;
    logic [NUM_REQ-1:0][1:0]    io_req_op;
    logic [NUM_REQ-1:0][31:0]   io_req_arg;
    logic [NUM_REQ-1:0]         io_req_ready;
    logic [31:0]                io_unit_in;
    logic [31:0]                io_sin_out;
    logic [31:0]                io_cos_out;
    logic                       io_resp_valid;
    logic [ID_W-1:0]            io_resp_id;
    logic [1:0]                 io_resp_op;
    logic [31:0]                io_resp_sin;
    logic [31:0]                io_resp_cos;
    logic [CNT_W-1:0]           io_inflight;

    modport slave (
        input  io_enable, io_req_valid, io_req_op, io_req_arg, io_sin_out, io_cos_out,
        output io_req_ready, io_unit_in, io_resp_valid, io_resp_id, io_resp_op,
               io_resp_sin, io_resp_cos, io_inflight
    );

    modport master (
        output io_enable, io_req_valid, io_req_op, io_req_arg, io_sin_out, io_cos_out,
        input  io_req_ready, io_unit_in, io_resp_valid, io_resp_id, io_resp_op,
               io_resp_sin, io_resp_cos, io_inflight
    );

endinterface

// File: rtl/trig_rr_arbiter.sv
// NUM_REQ-way round-robin arbiter. Search starts at rr_ptr and wraps; the
// pointer moves one past the winner and only when something is granted.
module trig_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               granted
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        granted   = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (enable && !reset && !granted && valid[cand]) begin
                granted     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            rr_ptr <= '0;
        else if (granted)
            rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/trig_issue_scheduler.sv
// Shares one Sin/Cos pipeline pair among NUM_REQ requesters; a shadow line
// mirrors the untagged units so each result returns to its originator.
module trig_issue_scheduler
    import trig_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = TRIG_LATENCY,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int CNT_W   = $clog2(LATENCY + 3)
) (
    input  logic                    clock,
    input  logic                    reset,
    trig_issue_scheduler_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY + 2);

    logic [NUM_REQ-1:0]        gnt;
    logic [ID_W-1:0]           gnt_idx;
    logic                      xfer;

    shadow_t                   iss;
    logic [31:0]               iss_arg;
    shadow_t [LATENCY-1:0]     sh_pipe;
    shadow_t                   last;

    logic                      resp_valid;
    logic [ID_W-1:0]           resp_id;
    logic [1:0]                resp_op;
    logic [31:0]               resp_sin;
    logic [31:0]               resp_cos;
    logic [CNT_W-1:0]          inflight;

    trig_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .enable    (bus.io_enable),
        .valid     (bus.io_req_valid),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .granted   (xfer)
    );

    // An idle cycle issues a zero operand so the units see a clean input.
    always_ff @(posedge clock) begin
        if (reset || !xfer) begin
            iss     <= '0;
            iss_arg <= '0;
        end else begin
            iss.v   <= 1'b1;
            iss.id  <= MAX_ID_W'(gnt_idx);
            iss.op  <= norm_op(bus.io_req_op[gnt_idx]);
            iss_arg <= bus.io_req_arg[gnt_idx];
        end
    end

    // Last stage lines up with the unit outputs.
    always_ff @(posedge clock) begin
        if (reset)
            sh_pipe <= '0;
        else
            sh_pipe <= {sh_pipe[LATENCY-2:0], iss};
    end

    assign last = sh_pipe[LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_op    <= '0;
            resp_sin   <= '0;
            resp_cos   <= '0;
        end else begin
            resp_valid <= last.v;
            if (last.v) begin
                resp_id  <= last.id[ID_W-1:0];
                resp_op  <= last.op;
                resp_sin <= (last.op == OP_COS) ? 32'h0 : bus.io_sin_out;
                resp_cos <= (last.op == OP_SIN) ? 32'h0 : bus.io_cos_out;
            end
        end
    end

    // Accept and retire in the same cycle cancel out.
    always_ff @(posedge clock) begin
        if (reset)
            inflight <= '0;
        else if (xfer && !resp_valid && inflight != CNT_MAX)
            inflight <= inflight + 1'b1;
        else if (!xfer && resp_valid && inflight != '0)
            inflight <= inflight - 1'b1;
    end

    assign bus.io_req_ready  = gnt;
    assign bus.io_unit_in    = iss_arg;
    assign bus.io_resp_valid = resp_valid;
    assign bus.io_resp_id    = resp_id;
    assign bus.io_resp_op    = resp_op;
    assign bus.io_resp_sin   = resp_sin;
    assign bus.io_resp_cos   = resp_cos;
    assign bus.io_inflight   = inflight;

endmodule

// File: doc/trig_issue_scheduler.md
# trig_issue_scheduler

Shares one `Sin` and one `Cos` pipeline pair among `NUM_REQ` requesters. The scheduler arbitrates round-robin and issues at most one operand per cycle to both units. Because the units carry no valid or tag, it tracks each in-flight operation with a `LATENCY`-deep shadow delay line and returns a tagged result to the originating requester. It sits between the trig-using clients and the free-running CORDIC-style `Sin`/`Cos` blocks.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2..8).
- `LATENCY`, 46: cycles from a value on the unit `io_in` to its result on `io_out`.
- `ID_W`, `$clog2(NUM_REQ)`: requester id width.
- `CNT_W`, `$clog2(LATENCY+3)`: in-flight counter width.

Ports (clock and reset first):
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_enable`  in  1  0 blocks new grants; in-flight operations still drain.
- `io_req_valid`  in  NUM_REQ  per-requester request.
- `io_req_op`  in  2*NUM_REQ  op per requester: 00 sin, 01 cos, 10 sincos, 11 reserved (executes as 10).
- `io_req_arg`  in  32*NUM_REQ  IEEE-754 single angle in radians.
- `io_req_ready`  out  NUM_REQ  one-hot grant; zero or one bit set.
- `io_unit_in`  out  32  operand driven to both `Sin.io_in` and `Cos.io_in`.
- `io_sin_out`  in  32  from `Sin.io_out`.
- `io_cos_out`  in  32  from `Cos.io_out`.
- `io_resp_valid`  out  1  one-cycle result strobe; no backpressure.
- `io_resp_id`  out  ID_W  originating requester.
- `io_resp_op`  out  2  op as executed (11 reported as 10).
- `io_resp_sin`  out  32  sin result; 0 when op is cos.
- `io_resp_cos`  out  32  cos result; 0 when op is sin.
- `io_inflight`  out  CNT_W  operations accepted but not yet responded.

## Operation
- Grant (combinational):
  - Active only when `io_enable` = 1 and `reset` = 0.
  - Searches from `rr_ptr` upward with wrap; the first requester with `io_req_valid[i]` = 1 gets `io_req_ready[i]` = 1.
  - A transfer occurs when valid and ready are both 1 for the same requester.
- `rr_ptr`: on a transfer at index i it becomes (i+1) mod NUM_REQ. It is unchanged when nothing is granted.
- Issue register: on a transfer it captures arg, id and op with `v`=1. With no transfer it loads `v`=0 and arg=0, so an idle `io_unit_in` is 0.
  - `io_unit_in` is the issue register's arg.
- Shadow line: `LATENCY` stages of {v, id, op} fed from the issue register. Stage LATENCY-1 is aligned with `io_sin_out`/`io_cos_out`.
- Retire: when the last stage has v=1, the response register loads id, op and the selected results, with the unused result forced to 0, and `io_resp_valid`=1 for one cycle.
  - Otherwise `io_resp_valid`=0 and the data fields hold their previous values.
- `io_inflight`: +1 on a transfer, −1 on `io_resp_valid`, unchanged when both occur. Maximum is LATENCY+2; it never wraps.
- Pipeline operands cannot stall, so consumers must accept every response strobe.

## Timing
- Reset values: `io_req_ready`=0, `io_unit_in`=0, `io_resp_valid`=0, `io_resp_id`=0, `io_resp_op`=0, `io_resp_sin`=0, `io_resp_cos`=0, `io_inflight`=0, `rr_ptr`=0, all shadow v=0.
- Transfer in cycle T:
  - `io_unit_in` carries the arg in cycle T+1.
  - The unit result appears in cycle T+1+LATENCY.
  - `io_resp_valid` is high in cycle T+2+LATENCY (48 for the default).
- Throughput: one operation per cycle. Results come back in acceptance order.
- Reset mid-flight: every shadow v and the response are cleared in the reset cycle. No stale response is ever emitted for pre-reset requests.
- `io_enable` falling: grants stop in that same cycle; outstanding results still arrive on schedule.
- Simultaneous valid from all requesters: exactly one grant per cycle, with strict rotation.

## Structure
- Shared package `trig_pkg`:
  - op encodings `OP_SIN`, `OP_COS`, `OP_SINCOS`;
  - `TRIG_LATENCY` = 46;
  - the shadow-entry struct {v, id, op}.
- Sub-module `trig_rr_arbiter`: NUM_REQ-way round-robin, with inputs valid and enable and outputs the one-hot grant and the encoded index; holds `rr_ptr`.
- The top level instantiates the arbiter, the issue register, the shadow shift register and the response register. `Sin`/`Cos` are instantiated outside.

## Test plan
- Single request, requester 2, op 00, arg 32'h3ffb53d8 at T -> `io_resp_valid` at T+48, id=2, sin ≈ 32'h3f6c835e (within 1e-5), cos=0.
- Requester 0, op 10, arg 32'h00000000 -> one response with sin ≈ 0 and cos ≈ 32'h3f800000; `io_inflight` is 1 throughout and 0 afterwards.
- All 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 on consecutive cycles; responses arrive in the same order on 8 consecutive cycles from T+48; `io_inflight` peaks at 8.
- Continuous issue for 60 cycles -> retire and accept coincide; `io_inflight` holds 47 or 48 and never exceeds LATENCY+2.
- `io_enable`=0 with requests pending -> `io_req_ready`=0; outstanding responses still arrive; after enable returns, the grant resumes at `rr_ptr`.
- Reset asserted 20 cycles after 5 transfers -> no `io_resp_valid` in the following 60 cycles, and all outputs hold their reset values.
